corescore_stream_arbiter: RTL

CORESCORE_STREAM_ARBITER -- requirements
Module: corescore_stream_arbiter

---
 rtl/corescore_pkg.sv | 9 +
 rtl/corescore_stream_arbiter_if.sv | 12 +
 rtl/corescore_rr_sel.sv | 28 ++
 rtl/corescore_stream_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/corescore_pkg.sv
// rtl/corescore_pkg.sv - shared defaults and FSM encoding for the stream arbiter
package corescore_pkg;

   localparam int DATA_W_DEF = 8;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/corescore_stream_arbiter_if.sv
// rtl/corescore_stream_arbiter_if.sv - single AXI-Stream-like link (merged output side)
interface corescore_stream_arbiter_if #(
   parameter int DATA_W = corescore_pkg::DATA_W_DEF
);
   logic [DATA_W-1:0] tdata;
   logic              tlast;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/corescore_rr_sel.sv
// rtl/corescore_rr_sel.sv - round-robin winner pick: request vector + last owner -> one-hot grant
module corescore_rr_sel #(
   parameter int NUM_SRC = 4,
   parameter int IW      = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] i_req,
   input  logic [IW-1:0]      i_last,
   output logic [NUM_SRC-1:0] o_grant
);

   logic [IW-1:0] w_idx;
   logic          w_found;

   // Search begins one past the last owner and wraps, so the last owner is checked last.
   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         w_idx = IW'((int'(i_last) + k) % NUM_SRC);
         if (!w_found && i_req[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            w_found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/corescore_stream_arbiter.sv
// rtl/corescore_stream_arbiter.sv - packet-locked round-robin merge of NUM_SRC streams into one
module corescore_stream_arbiter
   import corescore_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [NUM_SRC*DATA_W-1:0] i_tdata,
   input  logic [NUM_SRC-1:0]        i_tlast,
   input  logic [NUM_SRC-1:0]        i_tvalid,
   output logic [NUM_SRC-1:0]        o_tready,
   output logic [DATA_W-1:0]         o_tdata,
   output logic                      o_tlast,
   output logic                      o_tvalid,
   input  logic                      i_tready,
   output logic [NUM_SRC-1:0]        o_grant
);

   localparam int IW = $clog2(NUM_SRC);

   logic [0:0]         r_state;
   logic [IW-1:0]      r_last_own;
   logic [NUM_SRC-1:0] r_grant;
   logic [DATA_W-1:0]  r_buf_data0, r_buf_data1;
   logic               r_buf_last0, r_buf_last1;
   logic [1:0]         r_cnt;

   logic [NUM_SRC-1:0] w_sel;
   logic [DATA_W-1:0]  w_own_data;
   logic               w_own_last;
   logic [IW-1:0]      w_own_idx;
   logic               w_not_full;
   logic               w_accept;
   logic               w_pop;

   corescore_rr_sel #(.NUM_SRC(NUM_SRC)) u_rr_sel (
      .i_req   (i_tvalid),
      .i_last  (r_last_own),
      .o_grant (w_sel)
   );

   always_comb begin
      w_own_data = '0;
      w_own_last = 1'b0;
      w_own_idx  = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (r_grant[k]) begin
            w_own_data = i_tdata[k*DATA_W +: DATA_W];
            w_own_last = i_tlast[k];
            w_own_idx  = IW'(k);
         end
      end
   end

   assign w_not_full = (r_cnt != 2'd2);
   assign o_tready   = (r_state == ST_LOCKED) ? (r_grant & {NUM_SRC{w_not_full}}) : '0;
   assign w_accept   = |(i_tvalid & o_tready);
   assign w_pop      = (r_cnt != 2'd0) && i_tready;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_last_own <= IW'(NUM_SRC - 1);
         r_grant    <= '0;
      end else if (r_state == ST_IDLE) begin
         if (|i_tvalid) begin
            r_grant <= w_sel;
            r_state <= ST_LOCKED;
         end
      end else if (w_accept && w_own_last) begin
         r_grant    <= '0;
         r_last_own <= w_own_idx;
         r_state    <= ST_IDLE;
      end
   end

   // Slot 0 is always the head; push+pop only happens at one entry since full blocks accept.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_buf_data0 <= '0;
         r_buf_data1 <= '0;
         r_buf_last0 <= 1'b0;
         r_buf_last1 <= 1'b0;
         r_cnt       <= 2'd0;
      end else begin
         case ({w_accept, w_pop})
            2'b10: begin
               if (r_cnt == 2'd0) begin
                  r_buf_data0 <= w_own_data;
                  r_buf_last0 <= w_own_last;
               end else begin
                  r_buf_data1 <= w_own_data;
                  r_buf_last1 <= w_own_last;
               end
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               r_buf_data0 <= r_buf_data1;
               r_buf_last0 <= r_buf_last1;
               r_cnt       <= r_cnt - 2'd1;
            end
            2'b11: begin
               r_buf_data0 <= w_own_data;
               r_buf_last0 <= w_own_last;
            end
            default: ;
         endcase
      end
   end

   assign o_tvalid = (r_cnt != 2'd0);
   assign o_tdata  = r_buf_data0;
   assign o_tlast  = r_buf_last0;
   assign o_grant  = r_grant;

endmodule
